branch_ctrl: RTL

Conditional-branch controller for the pipelined ARM core. It owns the architectural NZCV flag register, whose Z bit comes from the fast zero detector on the 64-bit ALU result. It resolves B, B.cond, CBZ and CBNZ in the ID stage and sequences the pipeline around them: it stalls ID until the branch operands are available, then raises a registered taken pulse and a flush window for the wrong-path fetch.

---
 rtl/branch_pkg.sv | 36 +++
 rtl/branch_ctrl_cond_check.sv | 38 +++
 rtl/branch_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the ID-stage branch controller: branch types, condition
// codes, FSM states and NZCV bit positions.
package branch_pkg;

   localparam logic [1:0] BR_B     = 2'b00;
   localparam logic [1:0] BR_BCOND = 2'b01;
   localparam logic [1:0] BR_CBZ   = 2'b10;
   localparam logic [1:0] BR_CBNZ  = 2'b11;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_HS = 4'b0010;
   localparam logic [3:0] COND_LO = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/branch_ctrl_cond_check.sv
// Combinational ARM condition-code evaluation against an NZCV flag set.
module cond_check
   import branch_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_true
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      cond_true = 1'b1;
      case (cond)
         COND_EQ: cond_true = z;
         COND_NE: cond_true = !z;
         COND_HS: cond_true = c;
         COND_LO: cond_true = !c;
         COND_MI: cond_true = n;
         COND_PL: cond_true = !n;
         COND_VS: cond_true = v;
         COND_VC: cond_true = !v;
         COND_HI: cond_true = c & !z;
         COND_LS: cond_true = !c | z;
         COND_GE: cond_true = (n == v);
         COND_LT: cond_true = (n != v);
         COND_GT: cond_true = !z & (n == v);
         COND_LE: cond_true = z | (n != v);
         default: cond_true = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution: owns NZCV, stalls until operands are ready, then
// issues a registered taken pulse and a flush window for the wrong-path fetch.
module branch_ctrl
   import branch_pkg::*;
#(
   parameter int unsigned FWD_FLAGS    = 1,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic             ex_setflags,
   input  logic [3:0]       ex_flags,
   input  logic             br_valid,
   input  logic [1:0]       br_type,
   input  logic [3:0]       br_cond,
   input  logic             op_ready,
   input  logic             op_zero,
   output logic             stall,
   output logic             br_taken,
   output logic             flush,
   output logic [3:0]       flags,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

   logic [1:0] state, state_nxt;
   logic [2:0] fcnt, fcnt_nxt;
   logic       taken_nxt, flush_nxt;
   logic       ex_flag_wr;
   logic [3:0] eff_flags;
   logic       cond_true;
   logic       resolvable, taken;

   assign ex_flag_wr = ex_valid & ex_setflags;
   assign eff_flags  = ((FWD_FLAGS != 0) && ex_flag_wr) ? ex_flags : flags;

   cond_check u_cond_check (
      .cond      (br_cond),
      .flags     (eff_flags),
      .cond_true (cond_true)
   );

   // Operand availability and direction for the branch currently in ID.
   always_comb begin
      resolvable = 1'b1;
      taken      = 1'b1;
      case (br_type)
         BR_B: begin
            resolvable = 1'b1;
            taken      = 1'b1;
         end
         BR_BCOND: begin
            resolvable = !((FWD_FLAGS == 0) && ex_flag_wr);
            taken      = cond_true;
         end
         BR_CBZ: begin
            resolvable = op_ready;
            taken      = op_zero;
         end
         default: begin
            resolvable = op_ready;
            taken      = !op_zero;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_RUN;
         fcnt     <= 3'd0;
         br_taken <= 1'b0;
         flush    <= 1'b0;
      end else begin
         state    <= state_nxt;
         fcnt     <= fcnt_nxt;
         br_taken <= taken_nxt;
         flush    <= flush_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      taken_nxt = 1'b0;
      flush_nxt = 1'b0;
      stall     = 1'b0;
      case (state)
         ST_RUN, ST_WAIT: begin
            stall = br_valid & !resolvable & !reset;
            if (br_valid && resolvable && taken) begin
               state_nxt = ST_FLUSH;
               fcnt_nxt  = FLUSH_LAST;
               taken_nxt = 1'b1;
               flush_nxt = 1'b1;
            end else if (br_valid && !resolvable) begin
               state_nxt = ST_WAIT;
            end else begin
               state_nxt = ST_RUN;
            end
         end
         ST_FLUSH: begin
            // Wrong-path br_valid is ignored for the whole window.
            if (fcnt == 3'd0) begin
               state_nxt = ST_RUN;
            end else begin
               fcnt_nxt  = fcnt - 3'd1;
               flush_nxt = 1'b1;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // The EX instruction is older than the branch, so flags always load.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= 4'b0000;
      end else if (ex_flag_wr) begin
         flags <= ex_flags;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule
